// File: rtl/bsg_manycore_host_io_pkg.sv
// bsg_manycore_host_io_pkg: shared drain-state enum and link field-width helpers
// Link sif layout, MSB first:
//   fwd_v | fwd_packet | fwd_ready_and_rev | rev_v | rev_packet | rev_ready_and_rev
package bsg_manycore_host_io_pkg;

    typedef enum logic [1:0] {eRun, eDrain, eDrained} host_io_drain_state_e;

    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // addr + data + src/dst coordinates + 2-bit opcode
    function automatic int fwd_packet_width(input int a, input int d, input int x, input int y);
        return a + d + 2 * (x + y) + 2;
    endfunction

    // data + return coordinates + 2-bit response type
    function automatic int rev_packet_width(input int d, input int x, input int y);
        return d + x + y + 2;
    endfunction

    function automatic int bsg_manycore_link_sif_width(input int a, input int d, input int x, input int y);
        return 4 + fwd_packet_width(a, d, x, y) + rev_packet_width(d, x, y);
    endfunction

endpackage

// File: rtl/bsg_manycore_host_io_credit_counter.sv
// bsg_manycore_host_io_credit_counter: per-channel outstanding host request counter
// Ports: clk_i/reset_i (async active-high), send_i (request accepted),
//        recv_i (response delivered), count_o, full_o (count == max_out_p),
//        err_o (sticky: response seen while count was 0)
module bsg_manycore_host_io_credit_counter
    import bsg_manycore_host_io_pkg::*;
#(
    parameter int max_out_p    = 16,
    parameter int cnt_width_lp = safe_clog2(max_out_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    send_i,
    input  logic                    recv_i,
    output logic [cnt_width_lp-1:0] count_o,
    output logic                    full_o,
    output logic                    err_o
);

    assign full_o = count_o == cnt_width_lp'(max_out_p);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_o <= '0;
            err_o   <= 1'b0;
        end else begin
            if (send_i & ~recv_i)
                count_o <= count_o + 1'b1;
            else if (recv_i & ~send_i & (count_o != '0))
                count_o <= count_o - 1'b1;
            if (recv_i & (count_o == '0))
                err_o <= 1'b1;
        end
    end

endmodule

// File: rtl/bsg_manycore_host_io_mux.sv
// bsg_manycore_host_io_mux: maps host channels onto io columns with credit throttling and drain
// Ports: clk_i/reset_i (async active-high); host_link_sif_i/o per host channel;
//        io_link_sif_i/o per io column; drain_i level quiesce request;
//        drained_o high when quiesced; outstanding_o per-channel count;
//        err_o per-channel sticky underflow flag
module bsg_manycore_host_io_mux
    import bsg_manycore_host_io_pkg::*;
#(
    parameter int addr_width_p      = 8,
    parameter int data_width_p      = 8,
    parameter int x_cord_width_p    = 2,
    parameter int y_cord_width_p    = 2,
    parameter int num_tiles_x_p     = 4,
    parameter int num_host_p        = 1,
    parameter int max_out_p         = 16,
    parameter int cnt_width_lp      = safe_clog2(max_out_p + 1),
    parameter int link_sif_width_lp = bsg_manycore_link_sif_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p)
) (
    input  logic                                        clk_i,
    input  logic                                        reset_i,
    input  logic [num_host_p-1:0][link_sif_width_lp-1:0]    host_link_sif_i,
    output logic [num_host_p-1:0][link_sif_width_lp-1:0]    host_link_sif_o,
    input  logic [num_tiles_x_p-1:0][link_sif_width_lp-1:0] io_link_sif_i,
    output logic [num_tiles_x_p-1:0][link_sif_width_lp-1:0] io_link_sif_o,
    input  logic                                        drain_i,
    output logic                                        drained_o,
    output logic [num_host_p-1:0][cnt_width_lp-1:0]     outstanding_o,
    output logic [num_host_p-1:0]                       err_o
);

    localparam int rev_pkt_lp = rev_packet_width(data_width_p, x_cord_width_p, y_cord_width_p);
    localparam int rr_lp      = 0;
    localparam int rv_lp      = rev_pkt_lp + 1;
    localparam int fr_lp      = rev_pkt_lp + 2;
    localparam int fv_lp      = link_sif_width_lp - 1;

    host_io_drain_state_e state_r;
    logic [num_host_p-1:0] full, blk, send, recv, zero;

    for (genvar i = 0; i < num_host_p; i++) begin : ch
        // Registered count and state only, so ready never feeds back into valid
        assign blk[i]  = full[i] | (state_r != eRun);
        assign send[i] = host_link_sif_i[i][fv_lp] & ~blk[i] & io_link_sif_i[i][fr_lp];
        assign recv[i] = io_link_sif_i[i][rv_lp] & host_link_sif_i[i][rr_lp];
        assign zero[i] = outstanding_o[i] == '0;
        assign io_link_sif_o[i]   = {host_link_sif_i[i][fv_lp] & ~blk[i], host_link_sif_i[i][fv_lp-1:0]};
        assign host_link_sif_o[i] = {io_link_sif_i[i][link_sif_width_lp-1:fr_lp+1],
                                     io_link_sif_i[i][fr_lp] & ~blk[i],
                                     io_link_sif_i[i][fr_lp-1:0]};
        bsg_manycore_host_io_credit_counter #(
            .max_out_p(max_out_p),
            .cnt_width_lp(cnt_width_lp)
        ) cnt (
            .clk_i(clk_i),
            .reset_i(reset_i),
            .send_i(send[i]),
            .recv_i(recv[i]),
            .count_o(outstanding_o[i]),
            .full_o(full[i]),
            .err_o(err_o[i])
        );
    end

    // Unattached columns never issue valid and always accept, so stray traffic cannot wedge the row
    for (genvar j = num_host_p; j < num_tiles_x_p; j++) begin : tie
        logic unused;
        assign unused = ^io_link_sif_i[j];
        assign io_link_sif_o[j] = (link_sif_width_lp'(1) << fr_lp) | link_sif_width_lp'(1);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r   <= eRun;
            drained_o <= 1'b0;
        end else begin
            unique case (state_r)
                eRun: if (drain_i) state_r <= eDrain;
                eDrain:
                    if (!drain_i) state_r <= eRun;
                    else if (&zero) begin
                        state_r   <= eDrained;
                        drained_o <= 1'b1;
                    end
                eDrained:
                    if (!drain_i) begin
                        state_r   <= eRun;
                        drained_o <= 1'b0;
                    end
                default: begin
                    state_r   <= eRun;
                    drained_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_manycore_host_io_mux.sv
// tb_bsg_manycore_host_io_mux: randomized self-checking bench against a behavioural model
module tb_bsg_manycore_host_io_mux;

    localparam int AW = 8, DW = 8, XW = 2, YW = 2, NT = 4, NH = 2, MO = 4, CW = 3;
    // rev packet = 8+2+2+2 = 14, fwd packet = 8+8+8+2 = 26, sif = 4+26+14 = 44
    localparam int LW = 44, RR = 0, RV = 15, FR = 16, FV = 43;

    logic clk = 1'b0;
    logic reset_i;
    logic [NH-1:0][LW-1:0] host_i, host_o;
    logic [NT-1:0][LW-1:0] io_i, io_o;
    logic drain, drained;
    logic [NH-1:0][CW-1:0] outst;
    logic [NH-1:0] err;

    always #5 clk = ~clk;

    bsg_manycore_host_io_mux #(
        .addr_width_p(AW), .data_width_p(DW), .x_cord_width_p(XW), .y_cord_width_p(YW),
        .num_tiles_x_p(NT), .num_host_p(NH), .max_out_p(MO)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .host_link_sif_i(host_i), .host_link_sif_o(host_o),
        .io_link_sif_i(io_i), .io_link_sif_o(io_o),
        .drain_i(drain), .drained_o(drained),
        .outstanding_o(outst), .err_o(err)
    );

    int checks = 0, errors = 0;
    int cnt[NH];
    bit merr[NH];
    int mode; // 0 running, 1 draining, 2 drained

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit coin(input int p);
        return $urandom_range(99, 0) < p;
    endfunction

    function automatic logic [LW-1:0] rvec();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[LW-1:0];
    endfunction

    function automatic bit blocked(input int i);
        return cnt[i] == MO || mode != 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NH; i++) begin
            cnt[i] = 0;
            merr[i] = 0;
        end
        mode = 0;
    endtask

    task automatic drive(input int preq, input int prsp);
        for (int i = 0; i < NT; i++) begin
            io_i[i] = rvec();
            io_i[i][RV] = coin(prsp);
            io_i[i][FR] = coin(80);
        end
        for (int i = 0; i < NH; i++) begin
            host_i[i] = rvec();
            host_i[i][FV] = coin(preq);
            host_i[i][RR] = coin(80);
        end
    endtask

    task automatic check_links();
        logic [LW-1:0] e;
        for (int i = 0; i < NH; i++) begin
            e = host_i[i];
            e[FV] = host_i[i][FV] && !blocked(i);
            check($sformatf("io_o[%0d]", i), 64'(io_o[i]), 64'(e));
            e = io_i[i];
            e[FR] = io_i[i][FR] && !blocked(i);
            check($sformatf("host_o[%0d]", i), 64'(host_o[i]), 64'(e));
        end
        for (int j = NH; j < NT; j++) begin
            check($sformatf("tie_fwd_v[%0d]", j), 64'(io_o[j][FV]), 64'(0));
            check($sformatf("tie_rev_v[%0d]", j), 64'(io_o[j][RV]), 64'(0));
        end
    endtask

    task automatic check_regs();
        for (int i = 0; i < NH; i++) begin
            check($sformatf("outstanding[%0d]", i), 64'(outst[i]), 64'(cnt[i]));
            check($sformatf("err[%0d]", i), 64'(err[i]), 64'(merr[i]));
        end
        check("drained", 64'(drained), 64'(mode == 2));
    endtask

    task automatic step();
        bit s[NH], r[NH];
        bit allz;
        allz = 1;
        for (int i = 0; i < NH; i++) begin
            s[i] = host_i[i][FV] && !blocked(i) && io_i[i][FR];
            r[i] = io_i[i][RV] && host_i[i][RR];
            if (cnt[i] != 0) allz = 0;
        end
        @(posedge clk);
        for (int i = 0; i < NH; i++) begin
            if (r[i] && cnt[i] == 0) merr[i] = 1;
            if (s[i] && !r[i]) cnt[i]++;
            else if (r[i] && !s[i] && cnt[i] > 0) cnt[i]--;
        end
        if (mode == 0 && drain) mode = 1;
        else if (mode == 1 && !drain) mode = 0;
        else if (mode == 1 && allz) mode = 2;
        else if (mode == 2 && !drain) mode = 0;
        #1 check_regs();
    endtask

    task automatic async_reset();
        #1 reset_i = 1'b1;
        #1 model_reset();
        check_regs();
        #1 reset_i = 1'b0;
    endtask

    int preq[8] = '{90, 10, 60, 90, 20, 50, 80, 40};
    int prsp[8] = '{10, 90, 40, 10, 80, 50, 20, 60};
    int ptog[8] = '{0, 0, 0, 3, 3, 2, 5, 2};

    initial begin
        reset_i = 1'b1;
        drain = 1'b0;
        host_i = '0;
        io_i = '0;
        model_reset();
        #1 check_regs();
        check_links();
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        for (int p = 0; p < 8; p++) begin
            if (ptog[p] == 0) drain = 1'b0;
            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                if (coin(ptog[p])) drain = ~drain;
                drive(preq[p], prsp[p]);
                if ((c == 0 && (p == 3 || p == 6)) || (c == 150 && p >= 4)) async_reset();
                #1 check_links();
                step();
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsg_manycore_host_io_mux.md
# bsg_manycore_host_io_mux

Parametrised host-side I/O attachment for the manycore array's io row. It replaces the single hard-wired loader port at x=0 with `num_host_p` host channels mapped onto io columns 0..`num_host_p`-1, and ties off the remaining columns internally. Each channel tracks its host-initiated outstanding requests and throttles at a configurable limit. A global drain FSM quiesces all host traffic so software can safely reset or reconfigure, for example between kernel launches.

## Interface
Parameters:
- `addr_width_p`, "inv": link address width in words.
- `data_width_p`, "inv": link data width.
- `x_cord_width_p`, "inv": X coordinate width.
- `y_cord_width_p`, "inv": Y coordinate width.
- `num_tiles_x_p`, "inv": io columns presented by the array.
- `num_host_p`, 1: host channels. Legal range is 1..`num_tiles_x_p`.
- `max_out_p`, 16: per-channel limit on outstanding host requests. Must be ≥1.
- `cnt_width_lp`, `BSG_SAFE_CLOG2(max_out_p+1)`: counter width.
- `link_sif_width_lp`: derived with `bsg_manycore_link_sif_width`.

Ports:
- `clk_i`  in  1  single clock.
- `reset_i`  in  1  asynchronous, active-high reset.
- `host_link_sif_i`  in  [num_host_p][link_sif_width_lp]  from host channels.
- `host_link_sif_o`  out  [num_host_p][link_sif_width_lp]  to host channels.
- `io_link_sif_i`  in  [num_tiles_x_p][link_sif_width_lp]  from array io row.
- `io_link_sif_o`  out  [num_tiles_x_p][link_sif_width_lp]  to array io row.
- `drain_i`  in  1  level request to quiesce host-initiated traffic.
- `drained_o`  out  1  high when quiesced.
- `outstanding_o`  out  [num_host_p][cnt_width_lp]  per-channel outstanding count.
- `err_o`  out  [num_host_p]  sticky error: response arrived with count 0.

## Operation
- Channel i connects to io column i.
- Columns `num_host_p`..`num_tiles_x_p`-1 are tied off with `bsg_manycore_link_sif_tieoff`.
- Host-initiated requests travel on fwd, host→array.
  - `block_i` = (`count_i` == `max_out_p`) | (state != eRun).
  - io fwd v = host fwd v & ~`block_i`.
  - host fwd ready = io fwd ready & ~`block_i`.
  - Data passes straight through.
- Responses to host travel on rev, array→host, and are never gated.
- Array-initiated fwd requests and host rev responses to them pass through ungated and are not counted.
- Counter events:
  - `send_i` = io fwd v & io fwd ready on column i.
  - `recv_i` = io rev v & host rev ready on channel i.
  - send only: +1. recv only: −1. Both: unchanged.
  - recv with count 0: count stays 0 and `err_o[i]` sets. `err_o` clears only on reset.
- Drain FSM, states eRun, eDrain, eDrained:
  - eRun → eDrain when `drain_i`=1.
  - eDrain → eDrained when all counts are 0 and `drain_i`=1.
  - eDrain → eRun when `drain_i`=0.
  - eDrained → eRun when `drain_i`=0.
  - A count of 0 at entry still passes through eDrain for one cycle.
- `drained_o` = (state == eDrained).

## Timing
- All link paths are combinational; zero-cycle latency.
- `block_i` uses registered count and state only, so there is no combinational loop from ready to valid.
- At count == `max_out_p`, host fwd is blocked that cycle even if a response returns in the same cycle; the request is accepted the next cycle.
- `drain_i` rising at edge k: state is eDrain after edge k, and host requests are blocked from cycle k+1. The earliest `drained_o` is after edge k+1.
- Reset values (asynchronous, on `reset_i` assertion): counts 0, `err_o` 0, state eRun, `drained_o` 0.
- Reset mid-operation discards outstanding counts. Link outputs then follow inputs combinationally with `block_i`=0.

## Structure
- Shared package `bsg_manycore_host_io_pkg` holds the `host_io_drain_state_e` enum (eRun, eDrain, eDrained).
- Link structs come from `declare_bsg_manycore_link_sif_s`.
- Sub-module `bsg_manycore_host_io_credit_counter` is instantiated once per channel, generated.
  - Inputs: send, recv.
  - Outputs: count, full (count == `max_out_p`), err.

## Test plan
- **Pass-through.** `num_host_p`=2, `num_tiles_x_p`=4. One request on host 1 → appears on io column 1 in the same cycle. `outstanding_o[1]`=1 after the edge; response → 0.
- **Limit.** `max_out_p`=4, 5 back-to-back requests on host 0 with array ready=1 → 4 accepted, 5th stalled with host fwd ready=0. A response returns in that cycle → 5th accepted the following cycle; count stays 4.
- **Simultaneous.** Send and recv on the same edge with count 2 → count stays 2, `err_o`=0.
- **Underflow.** Response with count 0 → `err_o[0]`=1 and held, count 0. Stays set until reset.
- **Drain.** `drain_i`=1 with counts {3,1} → host fwd valid suppressed from the next cycle. Return 4 responses → `drained_o`=1 one edge after the last. `drain_i`=0 → eRun and requests accepted again.
- **Async reset.** Assert `reset_i` mid-cycle with counts {2,2} in eDrain → counts 0, state eRun, `drained_o`=0 without a clock edge. Tied-off columns 2..3 never assert valid.
